// File: rtl/game_pkg.sv
// Shared game constants and the box state encoding.
// Screen height here also sets the default floor row.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLYING = 2'd1,
    HOLD   = 2'd2
  } box_state_t;

  localparam int SCREEN_H     = 120;
  localparam int Y_MAX_D      = SCREEN_H - 1;
  localparam int Y_W_D        = 7;
  localparam int FRAC_W_D     = 4;
  localparam int START_Y_D    = 60;
  localparam int GRAVITY_D    = 3;
  localparam int FLAP_VEL_D   = 40;
  localparam int MAX_FALL_D   = 64;
  localparam int HOLD_TICKS_D = 30;

endpackage

// File: rtl/box_physics_register_if.sv
// Control and status bundle between the game logic
// and the box physics register.
interface box_physics_register_if #(
  parameter int Y_W    = 7,
  parameter int FRAC_W = 4
);
  import game_pkg::*;

  logic                     tick;
  logic                     user_input;
  logic                     collided;
  logic [Y_W-1:0]           y_coordinate;
  logic signed [Y_W+FRAC_W:0] velocity;
  box_state_t               state;
  logic                     at_floor;
  logic                     at_ceiling;

  modport master (
    output tick, user_input, collided,
    input  y_coordinate, velocity, state,
    input  at_floor, at_ceiling
  );

  modport slave (
    input  tick, user_input, collided,
    output y_coordinate, velocity, state,
    output at_floor, at_ceiling
  );

endinterface

// File: rtl/rise_edge_detect.sv
// One-bit rising edge detector for synchronised key inputs.
// Previous level is registered; rise is high for one cycle.
module rise_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk) begin
    if (reset) prev <= 1'b0;
    else       prev <= din;
  end

  assign rise = din & ~prev;

endmodule

// File: rtl/box_physics_register.sv
// Box vertical position/velocity with frame-tick physics.
// BOX_WRAP_EN: warp at screen edges instead of clamping.
module box_physics_register
  import game_pkg::*;
#(
  parameter int Y_W        = Y_W_D,
  parameter int FRAC_W     = FRAC_W_D,
  parameter int Y_MAX      = Y_MAX_D,
  parameter int START_Y    = START_Y_D,
  parameter int GRAVITY    = GRAVITY_D,
  parameter int FLAP_VEL   = FLAP_VEL_D,
  parameter int MAX_FALL   = MAX_FALL_D,
  parameter int HOLD_TICKS = HOLD_TICKS_D
) (
  input logic                   game_clk,
  input logic                   reset,
  box_physics_register_if.slave bus
);

  localparam int P_W   = Y_W + FRAC_W;
  localparam int V_W   = P_W + 1;
  localparam int S_W   = P_W + 2;
  localparam int CNT_W = $clog2(HOLD_TICKS + 1);

  localparam logic [P_W-1:0] SPAWN =
    P_W'(START_Y << FRAC_W);
  localparam logic [P_W-1:0] FLOOR =
    P_W'(Y_MAX << FRAC_W);
  localparam logic [CNT_W-1:0] HOLD_LD =
    CNT_W'(HOLD_TICKS - 1);

  localparam logic signed [S_W-1:0] FLOOR_S =
    S_W'(Y_MAX << FRAC_W);
  localparam logic signed [S_W-1:0] GRAV_S =
    S_W'(GRAVITY);
  localparam logic signed [S_W-1:0] FLAP_S =
    S_W'(FLAP_VEL);
  localparam logic signed [S_W-1:0] MAXF_S =
    S_W'(MAX_FALL);

  box_state_t              st;
  logic [P_W-1:0]          pos;
  logic signed [V_W-1:0]   vel;
  logic                    flap_pending;
  logic [CNT_W-1:0]        hold_cnt;
  logic                    floor_q;
  logic                    ceil_q;
  logic                    key_rise;

  logic signed [S_W-1:0]   v_sum;
  logic signed [S_W-1:0]   v_new;
  logic signed [S_W-1:0]   p_new;
  logic [P_W-1:0]          nxt_pos;
  logic signed [V_W-1:0]   nxt_vel;

  rise_edge_detect u_key (
    .clk   (game_clk),
    .reset (reset),
    .din   (bus.user_input),
    .rise  (key_rise)
  );

  function automatic logic floor_of(
    input logic [P_W-1:0] p
  );
    return p[P_W-1:FRAC_W] == Y_W'(Y_MAX);
  endfunction

  function automatic logic ceil_of(
    input logic [P_W-1:0] p
  );
    return p == '0;
  endfunction

  // Semi-implicit Euler: velocity first, then position.
  always_comb begin
    v_sum = S_W'(vel) + GRAV_S;
    if (flap_pending)
      v_new = -FLAP_S;
    else if (v_sum > MAXF_S)
      v_new = MAXF_S;
    else
      v_new = v_sum;
    p_new   = $signed({2'b00, pos}) + v_new;
    nxt_pos = p_new[P_W-1:0];
    nxt_vel = v_new[V_W-1:0];
    if (p_new > FLOOR_S) begin
`ifdef BOX_WRAP_EN
      nxt_pos = '0;
`else
      nxt_pos = FLOOR;
      nxt_vel = '0;
`endif
    end else if (p_new[S_W-1]) begin
`ifdef BOX_WRAP_EN
      nxt_pos = FLOOR;
`else
      nxt_pos = '0;
      nxt_vel = '0;
`endif
    end
  end

  always_ff @(posedge game_clk) begin
    if (reset) begin
      st           <= IDLE;
      pos          <= SPAWN;
      vel          <= '0;
      flap_pending <= 1'b0;
      hold_cnt     <= '0;
      floor_q      <= 1'b0;
      ceil_q       <= 1'b0;
    end else if (bus.collided) begin
      st           <= HOLD;
      pos          <= SPAWN;
      vel          <= '0;
      flap_pending <= 1'b0;
      hold_cnt     <= HOLD_LD;
      floor_q      <= floor_of(SPAWN);
      ceil_q       <= ceil_of(SPAWN);
    end else begin
      case (st)
        HOLD: begin
          flap_pending <= 1'b0;
          if (bus.tick) begin
            if (hold_cnt == '0) st <= IDLE;
            else hold_cnt <= hold_cnt - 1'b1;
          end
        end
        IDLE, FLYING: begin
          if (bus.tick) begin
            flap_pending <= key_rise;
            if (st == FLYING || flap_pending) begin
              st      <= FLYING;
              pos     <= nxt_pos;
              vel     <= nxt_vel;
              floor_q <= floor_of(nxt_pos);
              ceil_q  <= ceil_of(nxt_pos);
            end
          end else begin
            flap_pending <= flap_pending | key_rise;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign bus.y_coordinate = pos[P_W-1:FRAC_W];
  assign bus.velocity     = vel;
  assign bus.state        = st;
  assign bus.at_floor     = floor_q;
  assign bus.at_ceiling   = ceil_q;

endmodule

// File: tb/tb_box_physics_register.sv
// Self-checking bench for box_physics_register.
// Directed scenarios plus random stimulus vs. a reference model.
module tb_box_physics_register;
  import game_pkg::*;

  localparam int FLOOR_P = 119 * 16;
  localparam int SPAWN_P = 60 * 16;

  logic game_clk = 1'b0;
  logic reset;

  box_physics_register_if #(.Y_W(7), .FRAC_W(4)) bus ();

  box_physics_register dut (
    .game_clk (game_clk),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 game_clk = ~game_clk;

  int checks = 0;
  int errors = 0;

  int m_pos, m_vel, m_st, m_hold;
  bit m_flap, m_key;

  task automatic check(input string tag, input int obs,
                       input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d",
               tag, obs, exp);
    end
  endtask

  // Reference: whole-pixel-agnostic integer physics.
  function automatic void model(bit r, bit t, bit u, bit c);
    bit rise = u && !m_key;
    int v, p;
    m_key = r ? 1'b0 : u;
    if (r) begin
      m_pos = SPAWN_P; m_vel = 0; m_st = 0;
      m_flap = 0; m_hold = 0;
    end else if (c) begin
      m_pos = SPAWN_P; m_vel = 0; m_st = 2;
      m_flap = 0; m_hold = 29;
    end else if (m_st == 2) begin
      m_flap = 0;
      if (t) begin
        if (m_hold == 0) m_st = 0;
        else m_hold--;
      end
    end else if (!t) begin
      m_flap = m_flap || rise;
    end else begin
      if (m_st == 1 || m_flap) begin
        if (m_flap) v = -40;
        else v = (m_vel + 3 > 64) ? 64 : m_vel + 3;
        p = m_pos + v;
        if (p > FLOOR_P) begin
`ifdef BOX_WRAP_EN
          p = 0;
`else
          p = FLOOR_P; v = 0;
`endif
        end else if (p < 0) begin
`ifdef BOX_WRAP_EN
          p = FLOOR_P;
`else
          p = 0; v = 0;
`endif
        end
        m_pos = p; m_vel = v; m_st = 1;
      end
      m_flap = rise;
    end
  endfunction

  task automatic step(bit r, bit t, bit u, bit c);
    reset          = r;
    bus.tick       = t;
    bus.user_input = u;
    bus.collided   = c;
    @(posedge game_clk);
    model(r, t, u, c);
    #1;
    check("y", int'(bus.y_coordinate), m_pos / 16);
    check("vel", int'(bus.velocity), m_vel);
    check("state", int'(bus.state), m_st);
    check("floor", int'(bus.at_floor),
          int'(m_pos / 16 == 119));
    check("ceil", int'(bus.at_ceiling), int'(m_pos == 0));
    check("vmax", int'(bus.velocity > 64), 0);
  endtask

  initial begin
    bit key;
    m_key = 0;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("rst_y", int'(bus.y_coordinate), 60);
    check("rst_st", int'(bus.state), 0);
    check("rst_flr", int'(bus.at_floor), 0);

    for (int i = 0; i < 10; i++) step(0, 1, 0, 0);
    check("idle_y", int'(bus.y_coordinate), 60);
    check("idle_v", int'(bus.velocity), 0);
    check("idle_st", int'(bus.state), 0);

    step(0, 0, 1, 0);
    step(0, 1, 1, 0);
    check("flap_v", int'(bus.velocity), -40);
    check("flap_y", int'(bus.y_coordinate), 57);
    check("flap_st", int'(bus.state), 1);

    step(0, 1, 1, 0);
    check("held_v", int'(bus.velocity), -37);

    for (int i = 0; i < 70; i++) step(0, 1, 0, 0);
`ifdef BOX_WRAP_EN
    check("wrap_v", int'(bus.velocity), 64);
`else
    check("gnd_y", int'(bus.y_coordinate), 119);
    check("gnd_v", int'(bus.velocity), 0);
    check("gnd_f", int'(bus.at_floor), 1);
`endif

    step(0, 0, 0, 1);
    check("col_y", int'(bus.y_coordinate), 60);
    check("col_v", int'(bus.velocity), 0);
    check("col_st", int'(bus.state), 2);
    for (int i = 0; i < 29; i++) begin
      step(0, 0, 1, 0);
      step(0, 1, 0, 0);
    end
    check("hold29", int'(bus.state), 2);
    step(0, 1, 1, 0);
    check("hold30", int'(bus.state), 0);
    check("hold_v", int'(bus.velocity), 0);

    step(0, 1, 0, 0);
    step(1, 1, 1, 1);
    check("rcol_st", int'(bus.state), 0);
    check("rcol_y", int'(bus.y_coordinate), 60);

    key = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) key = ~key;
      step($urandom_range(0, 599) == 0,
           $urandom_range(0, 2) == 0,
           key,
           $urandom_range(0, 249) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
